// File: rtl/transpose_sched_pkg.sv
// Shared definitions for the transpose scheduler: state encoding, default
// geometry and a counter-width helper.
package transpose_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_LANES  = 8;
  localparam int DEF_ROWS   = 2;
  localparam int DEF_SETTLE = 2;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transpose_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the side that did not win
// last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  // Pick the single requester, or alternate when both are asking.
  always_comb begin
    any   = |req;
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/transpose_sched.sv
// Sequencer for one shared transpose unit. Two requesters are arbitrated
// round-robin; the winner owns the unit for a full fill + drain.
module transpose_sched
  import transpose_sched_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LANES  = DEF_LANES,
  parameter int ROWS   = DEF_ROWS,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s0_valid,
  output logic                   s0_ready,
  input  logic [LANES*WIDTH-1:0] s0_data,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [LANES*WIDTH-1:0] s1_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ROWS*WIDTH-1:0]  m_data,
  output logic                   m_id,
  output logic                   m_last,
  output logic                   tp_en,
  output logic [LANES*WIDTH-1:0] tp_a,
  output logic                   tp_read,
  input  logic [ROWS*WIDTH-1:0]  tp_out,
  output logic                   busy
);

  localparam int FW = cnt_w(ROWS);
  localparam int RW = cnt_w(LANES);
  localparam int SW = cnt_w(SETTLE);

  localparam logic [FW-1:0] FILL_LAST   = FW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(LANES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t          state, state_nxt;
  logic [FW-1:0]   fill_cnt;
  logic [RW-1:0]   row_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            grant, last_grant;
  logic            arb_grant, arb_any;
  logic            sel_valid;

  rr_arb2 u_arb (
    .req        ({s1_valid, s0_valid}),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  // The transposer sees the granted requester's beat; its head row is
  // forwarded untouched, so it stays stable while the consumer stalls.
  assign tp_a   = grant ? s1_data : s0_data;
  assign m_data = tp_out;
  assign m_id   = grant;
  assign busy   = (state != ST_IDLE);

  // Next state and all handshake/strobe outputs.
  always_comb begin
    state_nxt = state;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    tp_en     = 1'b0;
    tp_read   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    sel_valid = grant ? s1_valid : s0_valid;
    unique case (state)
      ST_IDLE: begin
        if (arb_any) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        s0_ready = ~grant;
        s1_ready = grant;
        tp_en    = sel_valid;
        if (sel_valid && (fill_cnt == FILL_LAST)) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        m_last  = (row_cnt == ROW_LAST);
        if (m_ready) begin
          if (row_cnt == ROW_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            tp_read   = 1'b1;
            state_nxt = ST_SETTLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Grant latch and the fill/settle/row counters; each counter is cleared
  // on the transition that leaves its bound, so none ever wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      fill_cnt   <= '0;
      row_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          fill_cnt <= '0;
          if (arb_any) begin
            grant      <= arb_grant;
            last_grant <= arb_grant;
          end
        end
        ST_FILL: begin
          if (tp_en) begin
            if (fill_cnt == FILL_LAST) begin
              fill_cnt   <= '0;
              settle_cnt <= '0;
              row_cnt    <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        ST_OUT: begin
          if (tp_read) begin
            row_cnt    <= row_cnt + 1'b1;
            settle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transpose_sched.sv
// Scoreboard bench for transpose_sched with a behavioural transposer whose
// head row takes SETTLE cycles to reflect a strobe.
module tb_transpose_sched;

  localparam int W = 32;
  localparam int L = 8;
  localparam int R = 2;
  localparam int S = 2;

  typedef struct packed {
    logic           id;
    logic           last;
    logic [R*W-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             s0_valid, s1_valid;
  logic [L*W-1:0]   s0_data, s1_data;
  logic             s0_ready, s1_ready;
  logic             m_valid, m_ready, m_id, m_last;
  logic [R*W-1:0]   m_data;
  logic             tp_en, tp_read, busy;
  logic [L*W-1:0]   tp_a;
  logic [R*W-1:0]   tp_out;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   en_cnt = 0, rd_cnt = 0;
  int   rows_seen = 0, txn_count = 0, last_hs = 0;
  logic prev_valid = 1'b0, prev_busy = 1'b0, held_v = 1'b0;
  logic [R*W-1:0] held_d = '0;
  int   bp_txn = -1;
  int   hold_left = 5;
  logic meas_on = 1'b0;
  int   last_rise = -1, n_per = 0;

  always #5 clk = ~clk;

  transpose_sched #(.WIDTH(W), .LANES(L), .ROWS(R), .SETTLE(S)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_id(m_id), .m_last(m_last),
    .tp_en(tp_en), .tp_a(tp_a), .tp_read(tp_read), .tp_out(tp_out),
    .busy(busy)
  );

  // Behavioural transposer: stores ROWS beats, head row = lane ridx of each
  // beat, presented through a SETTLE-deep register chain.
  logic [W-1:0]   mem [R][L];
  int             wptr, ridx;
  logic [R*W-1:0] head, head_p1;

  always_comb begin
    head = '0;
    for (int k = 0; k < R; k++) head[k*W +: W] = mem[k][ridx];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= 0; ridx <= 0; head_p1 <= '0; tp_out <= '0;
      for (int k = 0; k < R; k++) for (int i = 0; i < L; i++) mem[k][i] <= '0;
    end else begin
      if (tp_en) begin
        for (int i = 0; i < L; i++) mem[wptr][i] <= tp_a[i*W +: W];
        wptr <= (wptr == R - 1) ? 0 : wptr + 1;
        if (wptr == 0) ridx <= 0;
      end
      if (tp_read) ridx <= ridx + 1;
      head_p1 <= head;
      tp_out  <= head_p1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [L*W-1:0] mk_beat(input logic [W-1:0] base);
    logic [L*W-1:0] b;
    for (int i = 0; i < L; i++) b[i*W +: W] = base + W'(i);
    return b;
  endfunction

  task automatic push_txn(input logic id, input logic [W-1:0] ba, input logic [W-1:0] bb);
    exp_t x;
    for (int r = 0; r < L; r++) begin
      x.id   = id;
      x.last = (r == L - 1);
      x.data[0 +: W] = ba + W'(r);
      x.data[W +: W] = bb + W'(r);
      sb.push_back(x);
    end
  endtask

  // Present two beats on requester k, optionally dropping valid in between.
  task automatic drive(input int k, input logic [W-1:0] ba, input logic [W-1:0] bb, input int stall);
    int n;
    for (int b = 0; b < 2; b++) begin
      if (k == 0) begin s0_valid = 1'b1; s0_data = mk_beat(b == 0 ? ba : bb); end
      else        begin s1_valid = 1'b1; s1_data = mk_beat(b == 0 ? ba : bb); end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(k == 0 ? s0_ready : s1_ready) && n < 400);
      if (n >= 400) begin
        n_cmp++; n_fail++;
        $display("FAIL ready_timeout: requester %0d got no ready, required ready within 400 cycles", k);
      end
      @(posedge clk); #1;
      if (k == 0) s0_valid = 1'b0; else s1_valid = 1'b0;
      if (b == 0 && stall > 0) begin
        repeat (stall) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle within 3000 cycles", busy, sb.size());
    end
  endtask

  // Consumer: accept every row except a 5-cycle stall on row 3 of the marked transaction.
  always @(posedge clk) begin
    #1;
    if (m_valid && txn_count == bp_txn && rows_seen == 3 && hold_left > 0) begin
      m_ready = 1'b0;
      hold_left--;
    end else begin
      m_ready = 1'b1;
    end
  end

  // Monitor: strobe counting, ready ownership, row spacing, hold, scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sb.delete();
      rows_seen  = 0;
      prev_valid = 1'b0;
      held_v     = 1'b0;
    end else begin
      if (tp_en)   en_cnt++;
      if (tp_read) rd_cnt++;
      if (tp_en && tp_read) chk("en_read_exclusive", 1, 0);
      if (s0_ready && s1_ready) chk("ready_exclusive", 1, 0);
      if ((s0_ready || s1_ready) && sb.size() != 0) chk("ready_owner", s1_ready, sb[0].id);
      if (busy && !prev_busy) begin
        if (meas_on && last_rise >= 0) begin
          n_cmp++; n_per++;
          if (cyc - last_rise < 27) begin
            n_fail++;
            $display("FAIL txn_period: got %0d cycles, required at least 27", cyc - last_rise);
          end
        end
        last_rise = meas_on ? cyc : -1;
      end
      if (m_valid && !prev_valid && rows_seen > 0) chk("row_gap", cyc - last_hs, S + 1);
      if (m_valid && !m_ready) begin
        if (held_v) begin
          chk("held_data", m_data, held_d);
          chk("no_read_in_stall", tp_read, 0);
        end
        held_v = 1'b1;
        held_d = m_data;
      end else begin
        held_v = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_row", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("row_data", m_data, e.data);
          chk("row_id", m_id, e.id);
          chk("row_last", m_last, e.last);
        end
        last_hs = cyc;
        if (m_last) begin rows_seen = 0; txn_count++; end
        else rows_seen++;
      end
      prev_valid = m_valid;
    end
    prev_busy = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, n;
    reset = 1'b1; m_ready = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_tp_en", tp_en, 0);
    chk("rst_tp_read", tp_read, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_id", m_id, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Both requesting from reset: s0 first, then s1.
    push_txn(1'b0, 32'h100, 32'h200);
    push_txn(1'b1, 32'h300, 32'h400);
    fork
      drive(0, 32'h100, 32'h200, 0);
      drive(1, 32'h300, 32'h400, 0);
    join
    wait_idle();

    // Single s0 transaction with strobe counts.
    e0 = en_cnt; r0 = rd_cnt;
    push_txn(1'b0, 32'h100, 32'h200);
    drive(0, 32'h100, 32'h200, 0);
    wait_idle();
    chk("single_tp_en", en_cnt - e0, 2);
    chk("single_tp_read", rd_cnt - r0, 7);

    // Both requesting after an s0 win: s1 first, then s0.
    push_txn(1'b1, 32'h500, 32'h600);
    push_txn(1'b0, 32'h700, 32'h800);
    fork
      drive(0, 32'h700, 32'h800, 0);
      drive(1, 32'h500, 32'h600, 0);
    join
    wait_idle();

    // Back-pressure on row 3.
    bp_txn = txn_count;
    push_txn(1'b0, 32'h900, 32'hA00);
    drive(0, 32'h900, 32'hA00, 0);
    wait_idle();
    chk("bp_hold_done", hold_left, 0);

    // Fill stall between beats.
    e0 = en_cnt; r0 = rd_cnt;
    push_txn(1'b0, 32'h100, 32'h200);
    drive(0, 32'h100, 32'h200, 4);
    wait_idle();
    chk("stall_tp_en", en_cnt - e0, 2);
    chk("stall_tp_read", rd_cnt - r0, 7);

    // Three back-to-back transactions.
    e0 = en_cnt; r0 = rd_cnt;
    meas_on = 1'b1;
    push_txn(1'b0, 32'hB00, 32'hC00);
    push_txn(1'b0, 32'hD00, 32'hE00);
    push_txn(1'b0, 32'hF00, 32'h1000);
    drive(0, 32'hB00, 32'hC00, 0);
    drive(0, 32'hD00, 32'hE00, 0);
    drive(0, 32'hF00, 32'h1000, 0);
    wait_idle();
    meas_on = 1'b0;
    chk("b2b_tp_en", en_cnt - e0, 6);
    chk("b2b_tp_read", rd_cnt - r0, 21);
    chk("b2b_periods", n_per, 2);

    // Reset while row 5 is being presented.
    push_txn(1'b0, 32'h1100, 32'h1200);
    drive(0, 32'h1100, 32'h1200, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(m_valid && rows_seen == 5) && n < 400);
    if (n >= 400) begin
      n_cmp++; n_fail++;
      $display("FAIL row5_timeout: rows_seen=%0d, required row 5 within 400 cycles", rows_seen);
    end
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s0_ready", s0_ready, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_tp_read", tp_read, 0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    // Fresh s1 transaction after the dropped one.
    push_txn(1'b1, 32'h1300, 32'h1400);
    drive(1, 32'h1300, 32'h1400, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
